// File: rtl/beam_pulse_rx.sv
// beam_pulse_rx: beam pulse receiver and monitor.
//
// Recovers the centroid of each one- or two-sample beam pulse in units of
// 1/phase_step cycle. It reports the scaled centroid-to-centroid interval,
// counts completed pulses and flags amplitude errors.
//
// Optional feature macro: BEAM_PULSE_RX_CHECK_EN enables the amplitude check.
// When it is undefined, amp_err is tied low and the second sample is taken raw.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset (deassertion synchronized here)
//   ena          state-advance qualifier; no state changes while low
//   clear        ena-qualified synchronous clear of count, amp_err and history
//   pulse        12-bit beam pulse sample stream
//   phase_step   expected integrated pulse amplitude
//   period       scaled centroid interval, cycles x phase_step
//   period_valid one-clk strobe when period is updated
//   period_sat   period was computed from a saturated accumulator
//   pulse_count  completed pulses since reset/clear (wraps)
//   amp_err      sticky amplitude-error flag
module beam_pulse_rx #(
  parameter int PW = 20,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ena,
  input  logic          clear,
  input  logic [11:0]   pulse,
  input  logic [11:0]   phase_step,
  output logic [PW-1:0] period,
  output logic          period_valid,
  output logic          period_sat,
  output logic [CW-1:0] pulse_count,
  output logic          amp_err
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_t;

  localparam logic [PW-1:0] ACC_MAX = {PW{1'b1}};

`ifdef BEAM_PULSE_RX_CHECK_EN
  // Two-sample pulse amplitude check; 13-bit sum so that no carry is lost.
  function automatic logic amp_sum_ok(input logic [11:0] a, input logic [11:0] b,
                                      input logic [11:0] step);
    return (({1'b0, a} + {1'b0, b}) == {1'b0, step});
  endfunction
`endif

  logic [1:0]    rst_sync_r;
  logic          rst_int_n_s;
  state_t        state_r, next_raw_s, next_state_s;
  logic [PW-1:0] acc_r, acc_hold_r, start_acc_s, step_ext_s;
  logic [PW:0]   acc_sum_s;
  logic          sat_r, sat_hold_r, start_sat_s;
  logic          start_raw_s, done_raw_s, start_s, done_s;
  logic [11:0]   b_s, b_prev_r;
  logic          hist_r;
  logic [PW-1:0] period_r;
  logic          period_valid_r, period_sat_r;
  logic [CW-1:0] pulse_count_r;
`ifdef BEAM_PULSE_RX_CHECK_EN
  logic [11:0]   a_r;
  logic          amp_hit_raw_s, amp_hit_s, amp_err_r;
`endif

  // Reset synchronizer: assertion is immediate, deassertion after two clk edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end
  assign rst_int_n_s = rst_sync_r[1];

  assign step_ext_s = PW'(phase_step);
  assign acc_sum_s  = {1'b0, acc_r} + {1'b0, step_ext_s};

  // Pulse recognition: decides pulse start, completion and the b term.
  always_comb begin
    next_raw_s  = state_r;
    start_raw_s = 1'b0;
    done_raw_s  = 1'b0;
    b_s         = 12'd0;
    start_acc_s = acc_r;
    start_sat_s = sat_r;
`ifdef BEAM_PULSE_RX_CHECK_EN
    amp_hit_raw_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (pulse != 12'd0) begin
          start_raw_s = 1'b1;
          // Oversize first samples are folded into single-sample pulses.
          if (pulse >= phase_step) begin
            done_raw_s = 1'b1;
`ifdef BEAM_PULSE_RX_CHECK_EN
            amp_hit_raw_s = (pulse != phase_step);
`endif
          end else begin
            next_raw_s = ST_SECOND;
          end
        end else begin
          next_raw_s = ST_IDLE;
        end
      end
      ST_SECOND: begin
        // The accumulator was reloaded at the first sample, so use the
        // value captured at that cycle.
        done_raw_s  = 1'b1;
        next_raw_s  = ST_IDLE;
        start_acc_s = acc_hold_r;
        start_sat_s = sat_hold_r;
`ifdef BEAM_PULSE_RX_CHECK_EN
        if (pulse == 12'd0) begin
          b_s           = phase_step - a_r;
          amp_hit_raw_s = 1'b1;
        end else begin
          b_s           = pulse;
          amp_hit_raw_s = !amp_sum_ok(a_r, pulse, phase_step);
        end
`else
        b_s = pulse;
`endif
      end
      default: begin
        next_raw_s = ST_IDLE;
      end
    endcase
  end

  // clear wins over any event in the same ena cycle.
  assign next_state_s = clear ? ST_IDLE : next_raw_s;
  assign start_s      = start_raw_s & ~clear;
  assign done_s       = done_raw_s & ~clear;
`ifdef BEAM_PULSE_RX_CHECK_EN
  assign amp_hit_s    = amp_hit_raw_s & ~clear;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      state_r <= ST_IDLE;
    end else if (ena) begin
      state_r <= next_state_s;
    end else begin
      state_r <= state_r;
    end
  end

  // Interval accumulator: reloads at each pulse start and saturates at all-ones.
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      acc_r <= '0;
      sat_r <= 1'b0;
    end else if (ena) begin
      if (clear) begin
        acc_r <= '0;
        sat_r <= 1'b0;
      end else if (start_s) begin
        acc_r <= step_ext_s;
        sat_r <= 1'b0;
      end else if (acc_sum_s > {1'b0, ACC_MAX}) begin
        acc_r <= ACC_MAX;
        sat_r <= 1'b1;
      end else begin
        acc_r <= acc_sum_s[PW-1:0];
      end
    end else begin
      acc_r <= acc_r;
    end
  end

  // Capture of accumulator state and first sample at pulse start.
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      acc_hold_r <= '0;
      sat_hold_r <= 1'b0;
`ifdef BEAM_PULSE_RX_CHECK_EN
      a_r        <= 12'd0;
`endif
    end else if (ena && start_s) begin
      acc_hold_r <= acc_r;
      sat_hold_r <= sat_r;
`ifdef BEAM_PULSE_RX_CHECK_EN
      a_r        <= pulse;
`endif
    end else begin
      acc_hold_r <= acc_hold_r;
    end
  end

  // Result registers: period/strobe, history, pulse counter.
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      period_r       <= '0;
      period_valid_r <= 1'b0;
      period_sat_r   <= 1'b0;
      pulse_count_r  <= '0;
      b_prev_r       <= 12'd0;
      hist_r         <= 1'b0;
    end else begin
      // The strobe lasts one clk no matter how sparse ena is.
      period_valid_r <= 1'b0;
      if (ena && clear) begin
        period_r      <= '0;
        period_sat_r  <= 1'b0;
        pulse_count_r <= '0;
        b_prev_r      <= 12'd0;
        hist_r        <= 1'b0;
      end else if (ena && done_s) begin
        pulse_count_r <= pulse_count_r + CW'(1);
        b_prev_r      <= b_s;
        hist_r        <= 1'b1;
        if (hist_r) begin
          period_r       <= start_acc_s + PW'(b_s) - PW'(b_prev_r);
          period_sat_r   <= start_sat_s;
          period_valid_r <= 1'b1;
        end else begin
          period_r <= period_r;
        end
      end else begin
        period_r <= period_r;
      end
    end
  end

`ifdef BEAM_PULSE_RX_CHECK_EN
  // Sticky amplitude error flag.
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      amp_err_r <= 1'b0;
    end else if (ena && clear) begin
      amp_err_r <= 1'b0;
    end else if (ena && done_s && amp_hit_s) begin
      amp_err_r <= 1'b1;
    end else begin
      amp_err_r <= amp_err_r;
    end
  end
  assign amp_err = amp_err_r;
`else
  assign amp_err = 1'b0;
`endif

  assign period       = period_r;
  assign period_valid = period_valid_r;
  assign period_sat   = period_sat_r;
  assign pulse_count  = pulse_count_r;

endmodule

// File: tb/tb_beam_pulse_rx.sv
module tb_beam_pulse_rx;
  localparam int PW = 20;
  localparam int CW = 16;
  localparam longint ACC_MAX = (64'd1 << PW) - 1;
`ifdef BEAM_PULSE_RX_CHECK_EN
  localparam logic AMP_EXP = 1'b1;
  localparam int   ZERO2_PERIOD = 135;
`else
  localparam logic AMP_EXP = 1'b0;
  localparam int   ZERO2_PERIOD = 143;
`endif

  logic          clk = 1'b0;
  logic          reset_n, ena, clear;
  logic [11:0]   pulse, phase_step;
  logic [PW-1:0] period;
  logic          period_valid, period_sat, amp_err;
  logic [CW-1:0] pulse_count;

  always #5 clk = ~clk;

  beam_pulse_rx #(.PW(PW), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .clear(clear),
    .pulse(pulse), .phase_step(phase_step), .period(period),
    .period_valid(period_valid), .period_sat(period_sat),
    .pulse_count(pulse_count), .amp_err(amp_err)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: centroids from ena-cycle indices, periods from
  // index differences times phase_step.
  longint m_t, m_ts, m_prev_ts, m_bprev, m_a, m_period, m_cnt;
  bit     m_inp, m_hist, m_amp, m_sat, m_pv;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_ts = 0; m_prev_ts = 0; m_bprev = 0; m_a = 0;
    m_period = 0; m_cnt = 0;
    m_inp = 0; m_hist = 0; m_amp = 0; m_sat = 0; m_pv = 0;
  endtask

  task automatic complete(input longint ts, input longint b);
    longint span;
    span = (ts - m_prev_ts) * longint'(phase_step);
    if (m_hist) begin
      m_period = ((span > ACC_MAX ? ACC_MAX : span) + b - m_bprev) & ACC_MAX;
      m_sat    = (span > ACC_MAX);
      m_pv     = 1;
    end
    m_prev_ts = ts;
    m_bprev   = b;
    m_hist    = 1;
    m_cnt     = (m_cnt + 1) % (64'd1 << CW);
  endtask

  task automatic model_tick(input bit en, input bit clr, input logic [11:0] p);
    longint b;
    m_pv = 0;
    if (en) begin
      if (clr) begin
        m_hist = 0; m_cnt = 0; m_amp = 0; m_period = 0; m_sat = 0; m_inp = 0;
      end else if (m_inp) begin
        b = p;
`ifdef BEAM_PULSE_RX_CHECK_EN
        if (p == 0) begin
          b = phase_step - m_a;
          m_amp = 1;
        end else if (m_a + p != phase_step) begin
          m_amp = 1;
        end
`endif
        complete(m_ts, b);
        m_inp = 0;
      end else if (p != 0) begin
        if (p >= phase_step) begin
`ifdef BEAM_PULSE_RX_CHECK_EN
          if (p > phase_step) m_amp = 1;
`endif
          complete(m_t, 0);
        end else begin
          m_inp = 1; m_a = p; m_ts = m_t;
        end
      end
      m_t++;
    end
  endtask

  // Every clock's outputs are compared with the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("period", 64'(period), m_period);
      chk("period_valid", 64'(period_valid), 64'(m_pv));
      chk("period_sat", 64'(period_sat), 64'(m_sat));
      chk("pulse_count", 64'(pulse_count), m_cnt);
      chk("amp_err", 64'(amp_err), 64'(m_amp));
    end
  end

  task automatic clk_cycle(input bit en, input bit clr, input logic [11:0] p);
    ena = en; clear = clr; pulse = p;
    @(posedge clk);
    if (reset_n) model_tick(en, clr, p);
    #1;
  endtask

  // One ena cycle: an ignored garbage clk, then the sampled clk.
  task automatic tick(input logic [11:0] p, input bit clr);
    clk_cycle(1'b0, 1'b0, 12'($urandom_range(1, 4095)));
    clk_cycle(1'b1, clr, p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(12'd0, 1'b0);
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst_period", 64'(period), 64'd0);
    chk("arst_count", 64'(pulse_count), 64'd0);
    repeat (3) clk_cycle(1'b0, 1'b0, 12'd0);
    reset_n = 1'b1;
    repeat (4) clk_cycle(1'b0, 1'b0, 12'd0);
  endtask

  int samp[20000];
  int ph;

  initial begin
    reset_n = 1'b0; ena = 1'b0; clear = 1'b0; pulse = 12'd0; phase_step = 12'd13;
    model_reset();
    repeat (3) clk_cycle(1'b0, 1'b0, 12'd0);
    cmp_en = 1'b1;
    clk_cycle(1'b0, 1'b0, 12'd0);
    chk("rst_period", 64'(period), 64'd0);
    chk("rst_valid", 64'(period_valid), 64'd0);
    chk("rst_sat", 64'(period_sat), 64'd0);
    chk("rst_count", 64'(pulse_count), 64'd0);
    chk("rst_amp", 64'(amp_err), 64'd0);
    reset_n = 1'b1;
    repeat (4) clk_cycle(1'b0, 1'b0, 12'd0);

    // Split pulses 100 ena cycles apart: 1300 + 4 - 8.
    tick(12'd5, 0); tick(12'd8, 0); idle(98); tick(12'd9, 0); tick(12'd4, 0);
    chk("split_valid", 64'(period_valid), 64'd1);
    idle(3);
    chk("split_period", 64'(period), 64'd1296);
    chk("split_count", 64'(pulse_count), 64'd2);

    // Single-sample pulses 102 apart.
    tick(12'd0, 1); tick(12'd13, 0); idle(101); tick(12'd13, 0); idle(2);
    chk("single_period", 64'(period), 64'd1326);
    chk("single_count", 64'(pulse_count), 64'd2);

    // Adjacent pulses.
    tick(12'd13, 0); tick(12'd13, 0); tick(12'd6, 0); tick(12'd7, 0); tick(12'd13, 0); idle(2);
    chk("adj_period", 64'(period), 64'd19);
    chk("adj_count", 64'(pulse_count), 64'd6);

    // Amplitude errors: bad sum, oversize first sample, zero second sample.
    tick(12'd0, 1); tick(12'd5, 0); tick(12'd7, 0); idle(2);
    chk("amp_sum", 64'(amp_err), 64'(AMP_EXP));
    idle(5); tick(12'd20, 0); idle(2);
    chk("oversize_period", 64'(period), 64'd110);
    chk("amp_sticky", 64'(amp_err), 64'(AMP_EXP));
    tick(12'd0, 1);
    chk("amp_clear", 64'(amp_err), 64'd0);
    tick(12'd5, 0); tick(12'd0, 0); idle(9); tick(12'd13, 0); idle(2);
    chk("zero2_period", 64'(period), 64'(ZERO2_PERIOD));

    // clear coincident with completion discards the pulse.
    tick(12'd0, 1); tick(12'd13, 0); idle(4); tick(12'd13, 0);
    chk("cc_pre_period", 64'(period), 64'd65);
    tick(12'd5, 0); tick(12'd8, 1);
    chk("cc_period", 64'(period), 64'd0);
    chk("cc_count", 64'(pulse_count), 64'd0);
    tick(12'd13, 0); idle(2);
    chk("cc_first_count", 64'(pulse_count), 64'd1);

    // Async reset while the second sample is awaited.
    tick(12'd13, 0); idle(5); tick(12'd13, 0); tick(12'd5, 0);
    async_reset();
    tick(12'd13, 0); idle(2);
    chk("rst2_count", 64'(pulse_count), 64'd1);
    chk("rst2_period", 64'(period), 64'd0);

    // Saturation boundary with a large phase_step.
    phase_step = 12'd4000;
    tick(12'd0, 1); tick(12'd4000, 0); idle(261); tick(12'd4000, 0);
    chk("nosat_period", 64'(period), 64'd1048000);
    chk("nosat_sat", 64'(period_sat), 64'd0);
    idle(262); tick(12'd4000, 0);
    chk("sat_period", 64'(period), 64'd1048575);
    chk("sat_sat", 64'(period_sat), 64'd1);
    chk("sat_valid", 64'(period_valid), 64'd1);
    idle(9); tick(12'd4000, 0);
    chk("post_sat_period", 64'(period), 64'd40000);
    chk("post_sat_sat", 64'(period_sat), 64'd0);

    // Nominal pulser: step 13, modulo 1320, split by fractional phase.
    phase_step = 12'd13;
    ph = 0;
    for (int i = 0; i < 20000; i++) begin
      ph += 13;
      if (ph >= 1320) begin
        ph -= 1320;
        if (ph == 0) begin
          samp[i] = 13;
        end else begin
          samp[i-1] = ph;
          samp[i]   = 13 - ph;
        end
      end
    end
    tick(12'd0, 1);
    for (int i = 0; i < 20000; i++) tick(12'(samp[i]), 0);
    idle(3);
    chk("nom_period", 64'(period), 64'd1320);
    chk("nom_count", 64'(pulse_count), 64'd196);
    chk("nom_amp", 64'(amp_err), 64'd0);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
